// File: rtl/rv32i_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// FSM state encoding and the access legality rule.
package rv32i_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;

  // Unsigned widths exist only for loads; halves and words must be naturally aligned.
  function automatic logic lsu_legal(input logic [2:0] funct3,
                                     input logic       we,
                                     input logic [1:0] off);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane of a memory word and extends it
// to 32 bits according to the load funct3.
module lsu_load_align
  import rv32i_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane extraction and sign/zero extension
  always_comb begin
    shifted_s = word >> {offset, 3'b000};
    byte_s    = shifted_s[7:0];
    half_s    = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_s[7]}}, byte_s};
      F3_BU:   result = {24'h000000, byte_s};
      F3_H:    result = {{16{half_s[15]}}, half_s};
      F3_HU:   result = {16'h0000, half_s};
      F3_W:    result = word;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end: issues one registered memory request per
// legal access, aligns/extends load data and traps illegal accesses.
module load_store_unit
  import rv32i_lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [31:0]       lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_fault,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_mask,
  input  logic [31:0]       mem_data_out
);

  lsu_state_e        state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic              req_q, req_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mdin_q, mdin_d;
  logic [3:0]        mmask_q, mmask_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              legal_s;
  logic [3:0]        st_mask_s;
  logic [31:0]       st_data_s;
  logic [31:0]       align_s;

  assign legal_s = lsu_legal(lsu_funct3, lsu_we, lsu_addr[1:0]);

  lsu_load_align u_align (
    .word   (mem_data_out),
    .offset (off_q),
    .funct3 (f3_q),
    .result (align_s)
  );

  // Store byte mask and lane-replicated store data
  always_comb begin
    case (lsu_funct3[1:0])
      2'b00: begin
        st_mask_s = 4'b0001 << lsu_addr[1:0];
        st_data_s = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        st_mask_s = lsu_addr[1] ? 4'b1100 : 4'b0011;
        st_data_s = {2{lsu_wdata[15:0]}};
      end
      2'b10: begin
        st_mask_s = 4'b1111;
        st_data_s = lsu_wdata;
      end
      default: begin
        st_mask_s = 4'b0000;
        st_data_s = 32'h0000_0000;
      end
    endcase
  end

  // Next-state and next-output computation
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    f3_d    = f3_q;
    we_d    = we_q;
    req_d   = req_q;
    mwe_d   = mwe_q;
    maddr_d = maddr_q;
    mdin_d  = mdin_q;
    mmask_d = mmask_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lsu_valid && legal_s) begin
          state_d = ST_ACCESS;
          off_d   = lsu_addr[1:0];
          f3_d    = lsu_funct3;
          we_d    = lsu_we;
          req_d   = 1'b1;
          mwe_d   = lsu_we;
          maddr_d = lsu_addr[ADDR_W+1:2];
          mdin_d  = lsu_we ? st_data_s : 32'h0000_0000;
          mmask_d = lsu_we ? st_mask_s : 4'b0000;
        end else if (lsu_valid) begin
          fault_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        req_d   = 1'b0;
        mwe_d   = 1'b0;
        mdin_d  = 32'h0000_0000;
        mmask_d = 4'b0000;
        if (we_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rdata_d = align_s;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; async reset also kills an in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= {ADDR_W{1'b0}};
      mdin_q  <= 32'h0000_0000;
      mmask_q <= 4'b0000;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      req_q   <= req_d;
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
      mdin_q  <= mdin_d;
      mmask_q <= mmask_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  assign lsu_stall   = (state_q == ST_IDLE) ? (lsu_valid & legal_s) : 1'b1;
  assign lsu_done    = done_q;
  assign lsu_fault   = fault_q;
  assign lsu_rdata   = rdata_q;
  assign mem_request = req_q;
  assign mem_we_re   = mwe_q;
  assign mem_address = maddr_q;
  assign mem_data_in = mdin_q;
  assign mem_mask    = mmask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory model,
// directed test-plan cases and randomized load/store traffic.
module tb_load_store_unit;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              lsu_valid, lsu_we;
  logic [2:0]        lsu_funct3;
  logic [31:0]       lsu_addr, lsu_wdata;
  logic              lsu_stall, lsu_done, lsu_fault;
  logic [31:0]       lsu_rdata;
  logic              mem_request, mem_we_re;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in, mem_data_out;
  logic [3:0]        mem_mask;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_fault(lsu_fault),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_mask(mem_mask), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_arr [0:255];
  logic [31:0] ref_mem [0:255];

  int          errors = 0;
  int          checks = 0;
  int          req_cnt = 0;
  bit          chk_en = 1'b0;
  logic        exp_legal, exp_we, last_fault;
  logic [7:0]  exp_waddr;
  logic [3:0]  exp_mask;
  logic [31:0] exp_din, exp_load, last_rdata;

  // Memory macro model: byte-masked write, read data valid the cycle after the read edge
  always @(posedge clk) begin
    if (mem_request) begin
      if (mem_we_re) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) mem_arr[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
      end else begin
        mem_data_out <= mem_arr[mem_address];
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    if (we && f3[2]) return 1'b0;
    return (int'(off) % acc_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] f3);
    int n = acc_size(f3);
    logic [31:0] m, v;
    if (n == 4) return word;
    m = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (word >> (8 * int'(off))) & m;
    if (!f3[2] && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] off,
                                            input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w = old;
    for (int i = 0; i < acc_size(f3); i++) w[8*(int'(off)+i) +: 8] = wd[8*i +: 8];
    return w;
  endfunction

  // Per-cycle compare of the memory interface and of the held load result
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (mem_request) begin
        req_cnt++;
        check("mem_we_re", {31'b0, mem_we_re}, {31'b0, exp_we});
        check("mem_address", {24'b0, mem_address}, {24'b0, exp_waddr});
        check("mem_mask", {28'b0, mem_mask}, {28'b0, exp_mask});
        check("mem_data_in", mem_data_in, exp_din);
      end
      if (!lsu_done) check("rdata_hold", lsu_rdata, last_rdata);
    end
  end

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] got);
    logic [1:0] off = addr[1:0];
    logic [7:0] widx = addr[9:2];
    int n = acc_size(f3);
    int edges = 0;
    bit fin = 1'b0;
    exp_legal = ref_legal(we, f3, off);
    exp_we    = we;
    exp_waddr = widx;
    exp_mask  = we ? 4'(((1 << n) - 1) << off) : 4'b0000;
    exp_din   = 32'h0;
    if (we) for (int j = 0; j < 4; j++) exp_din[8*j +: 8] = wd[8*(j % n) +: 8];
    exp_load  = ref_load(ref_mem[widx], off, f3);
    if (exp_legal && we) ref_mem[widx] = ref_store(ref_mem[widx], off, f3, wd);
    req_cnt    = 0;
    last_fault = 1'b0;
    lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    #1;
    check("stall_request", {31'b0, lsu_stall}, {31'b0, exp_legal});
    while (!fin && edges < 8) begin
      @(posedge clk); #1;
      edges++;
      if (lsu_done || lsu_fault) begin
        fin = 1'b1;
        last_fault = lsu_fault;
      end else begin
        check("stall_busy", {31'b0, lsu_stall}, {31'b0, exp_legal});
      end
    end
    if (!fin) begin
      check("timeout", 32'd0, 32'd1);
    end else begin
      check("fault", {31'b0, lsu_fault}, {31'b0, ~exp_legal});
      check("done", {31'b0, lsu_done}, {31'b0, exp_legal});
      check("latency", edges, exp_legal ? (we ? 2 : 3) : 1);
      check("req_count", req_cnt, exp_legal ? 1 : 0);
      if (!exp_legal) check("fault_noreq", {31'b0, mem_request}, 32'd0);
      if (exp_legal && !we) begin
        check("rdata", lsu_rdata, exp_load);
        last_rdata = exp_load;
      end
    end
    got = lsu_rdata;
  endtask

  task automatic idle(input int n);
    lsu_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rdata"}, lsu_rdata, 32'h0);
    check({tag, "_ctl"}, {24'b0, lsu_done, lsu_fault, mem_request, mem_we_re, mem_mask}, 32'h0);
    check({tag, "_maddr"}, {24'b0, mem_address}, 32'h0);
    check({tag, "_mdin"}, mem_data_in, 32'h0);
  endtask

  initial begin
    logic [31:0] got, r, wd;
    rst = 1'b0;
    lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b000; lsu_addr = 32'h0; lsu_wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[8'h10] = 32'h8899AABB;
    ref_mem[8'h10] = 32'h8899AABB;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset");
    check("reset_stall", {31'b0, lsu_stall}, 32'd0);
    rst = 1'b0;
    last_rdata = 32'h0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Directed loads of word 0x10
    run_txn(1'b0, 3'b010, 32'h40, 32'h0, got); check("lw_40", got, 32'h8899AABB); idle(1);
    run_txn(1'b0, 3'b000, 32'h43, 32'h0, got); check("lb_43", got, 32'hFFFFFF88); idle(1);
    run_txn(1'b0, 3'b100, 32'h43, 32'h0, got); check("lbu_43", got, 32'h00000088); idle(1);
    run_txn(1'b0, 3'b001, 32'h42, 32'h0, got); check("lh_42", got, 32'hFFFF8899); idle(1);
    run_txn(1'b0, 3'b101, 32'h40, 32'h0, got); check("lhu_40", got, 32'h0000AABB); idle(1);

    // Byte store then read-back
    run_txn(1'b1, 3'b000, 32'h41, 32'h000000CC, got);
    check("sb_mask_model", {28'b0, exp_mask}, 32'h2);
    check("sb_din_model", exp_din, 32'hCCCCCCCC);
    idle(1);
    run_txn(1'b0, 3'b010, 32'h40, 32'h0, got); check("lw_after_sb", got, 32'h8899CCBB); idle(1);

    // Illegal accesses
    run_txn(1'b0, 3'b010, 32'h42, 32'h0, got); check("lw42_fault", {31'b0, last_fault}, 32'd1); idle(1);
    run_txn(1'b1, 3'b001, 32'h41, 32'h1234, got); check("sh41_fault", {31'b0, last_fault}, 32'd1); idle(1);
    run_txn(1'b0, 3'b011, 32'h40, 32'h0, got); check("f3_011_fault", {31'b0, last_fault}, 32'd1); idle(1);
    run_txn(1'b1, 3'b100, 32'h40, 32'h55, got); check("sbu_fault", {31'b0, last_fault}, 32'd1); idle(1);

    // Back-to-back: next request presented in the lsu_done cycle
    run_txn(1'b0, 3'b010, 32'h40, 32'h0, got);
    run_txn(1'b1, 3'b010, 32'h44, 32'hDEADBEEF, got);
    run_txn(1'b0, 3'b010, 32'h44, 32'h0, got); check("b2b_lw_44", got, 32'hDEADBEEF);
    idle(1);

    // Reset while a store is in ACCESS
    lsu_valid = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'b010; lsu_addr = 32'h40; lsu_wdata = 32'h12345678;
    @(posedge clk); #1;
    check("rst_acc_req", {31'b0, mem_request}, 32'd1);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_outs("rst_acc");
    @(posedge clk); #1;
    check("rst_acc_mem", mem_arr[8'h10], 32'h8899CCBB);
    lsu_valid = 1'b0;
    rst = 1'b0;
    last_rdata = 32'h0;
    #1;
    check("rst_acc_stall", {31'b0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Randomized traffic over a small window of words
    for (int k = 0; k < 300; k++) begin
      r  = $urandom;
      wd = $urandom;
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              {r[31:10], 4'b0000, r[5:0]}, wd, got);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);
    for (int i = 0; i < 16; i++) check("final_mem", mem_arr[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
